// File: rtl/cache_types.sv
// cache_types: FSM state encoding and way-index width helper shared by cache_nway and plru_tree.
package cache_types;
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} cache_state_t;
    function automatic int way_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/plru_tree.sv
// plru_tree: combinational tree pseudo-LRU; heap-ordered nodes, bit=0 means the victim is in the left subtree.
module plru_tree
    import cache_types::*;
#(
    parameter int num_ways = 4,
    localparam int wb = way_bits(num_ways)
) (
    input  logic [num_ways-2:0] tree,
    input  logic [wb-1:0]       way,
    output logic [num_ways-2:0] tree_next,
    output logic [wb-1:0]       victim
);
    logic [wb-1:0] n, a;
    always_comb begin
        tree_next = tree;
        victim = '0;
        n = '0;
        a = '0;
        for (int l = 0; l < wb; l++) begin
            victim[wb-1-l] = tree[n];
            tree_next[a] = ~way[wb-1-l];
            n = n + n + wb'(1) + wb'(tree[n]);
            a = a + a + wb'(1) + wb'(way[wb-1-l]);
        end
    end
endmodule

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back/write-allocate cache with tree PLRU and miss FSM.
module cache_nway
    import cache_types::*;
#(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * 2**s_offset
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            mem_address,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [2**s_offset-1:0] mem_byte_enable256,
    input  logic [s_line-1:0]      mem_wdata256,
    output logic [s_line-1:0]      mem_rdata256,
    output logic                   mem_resp,
    output logic [31:0]            pmem_address,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [s_line-1:0]      pmem_wdata,
    input  logic [s_line-1:0]      pmem_rdata,
    input  logic                   pmem_resp
);
    localparam int num_sets = 2**s_index;
    localparam int wb = way_bits(num_ways);
    localparam logic [s_offset-1:0] zoff = '0;

    cache_state_t state;
    logic [s_tag-1:0]    tags  [num_sets][num_ways];
    logic [s_line-1:0]   data  [num_sets][num_ways];
    logic [num_ways-1:0] valid [num_sets];
    logic [num_ways-1:0] dirty [num_sets];
    logic [num_ways-2:0] plru  [num_sets];
    logic [num_ways-1:0] hits;
    logic [num_ways-2:0] plru_next;
    logic [wb-1:0]       victim, vsel, hit_way, free_way, plru_victim;
    logic [s_line-1:0]   merged;
    logic [s_index-1:0]  idx;
    logic [s_tag-1:0]    tag;
    logic                hit, has_free, unused_offset;

    assign idx = mem_address[s_offset +: s_index];
    assign tag = mem_address[31 -: s_tag];
    assign unused_offset = ^mem_address[s_offset-1:0];
    assign pmem_wdata = data[idx][victim];

    // Descending scan so the lowest-index invalid way wins allocation.
    always_comb begin
        hits = '0;
        hit_way = '0;
        free_way = '0;
        has_free = 1'b0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            hits[w] = valid[idx][w] && tags[idx][w] == tag;
            hit_way = hits[w] ? wb'(w) : hit_way;
            free_way = !valid[idx][w] ? wb'(w) : free_way;
            has_free = has_free || !valid[idx][w];
        end
        hit = |hits;
        vsel = has_free ? free_way : plru_victim;
        merged = data[idx][hit_way];
        for (int b = 0; b < 2**s_offset; b++)
            merged[8*b +: 8] = mem_byte_enable256[b] ? mem_wdata256[8*b +: 8] : merged[8*b +: 8];
    end

    plru_tree #(.num_ways(num_ways)) u_plru (
        .tree(plru[idx]),
        .way(hit_way),
        .tree_next(plru_next),
        .victim(plru_victim)
    );

    always_ff @(posedge clk) begin
        mem_resp <= 1'b0;
        if (!rst) begin
            state <= IDLE;
            pmem_read <= 1'b0;
            pmem_write <= 1'b0;
            pmem_address <= '0;
            for (int s = 0; s < num_sets; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s] <= '0;
            end
        end else case (state)
            // The held request is still visible during the response cycle; mem_resp keeps it from re-triggering.
            IDLE: state <= ((mem_read || mem_write) && !mem_resp) ? COMPARE : IDLE;
            COMPARE: if (hit) begin
                mem_resp <= 1'b1;
                mem_rdata256 <= mem_write ? merged : data[idx][hit_way];
                if (mem_write) begin
                    data[idx][hit_way] <= merged;
                    dirty[idx][hit_way] <= 1'b1;
                end
                plru[idx] <= plru_next;
                state <= IDLE;
            end else begin
                victim <= vsel;
                pmem_write <= dirty[idx][vsel];
                pmem_read <= !dirty[idx][vsel];
                pmem_address <= dirty[idx][vsel] ? {tags[idx][vsel], idx, zoff} : {tag, idx, zoff};
                state <= dirty[idx][vsel] ? WRITEBACK : FILL;
            end
            WRITEBACK: if (pmem_resp) begin
                dirty[idx][victim] <= 1'b0;
                pmem_write <= 1'b0;
                pmem_read <= 1'b1;
                pmem_address <= {tag, idx, zoff};
                state <= FILL;
            end
            FILL: if (pmem_resp) begin
                data[idx][victim] <= pmem_rdata;
                tags[idx][victim] <= tag;
                valid[idx][victim] <= 1'b1;
                dirty[idx][victim] <= 1'b0;
                pmem_read <= 1'b0;
                state <= COMPARE;
            end
        endcase
    end

    a_one_hit: assert property (@(posedge clk) disable iff (!rst) state == COMPARE |-> $onehot0(hits));
    a_req_held: assert property (@(posedge clk) disable iff (!rst) state != IDLE |-> (mem_read || mem_write));
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: scoreboard bench for cache_nway backed by a flat line-memory model.
module tb_cache_nway;
    import cache_types::*;
    logic clk, rst, mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [31:0] mem_address, mem_byte_enable256, pmem_address;
    logic [255:0] mem_wdata256, mem_rdata256, pmem_wdata, pmem_rdata;
    int vectors = 0;
    int miscompares = 0;
    typedef struct {logic chk; logic [255:0] line;} exp_t;
    typedef struct {logic wr; logic [31:0] addr; logic [255:0] data;} ptxn_t;
    exp_t exp_q[$];
    ptxn_t pmem_log[$];
    logic [255:0] store [logic [31:0]];
    logic [255:0] shadow [logic [31:0]];

    cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable256(mem_byte_enable256), .mem_wdata256(mem_wdata256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = {a[31:5], 5'(4*k)} ^ 32'h5A00_0000;
        return l;
    endfunction

    function automatic logic [255:0] model_line(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        return shadow.exists(la) ? shadow[la] : store.exists(la) ? store[la] : pat(la);
    endfunction

    function automatic void shadow_write(input logic [31:0] a, input logic [31:0] be, input logic [255:0] wd);
        logic [255:0] l;
        l = model_line(a);
        for (int b = 0; b < 32; b++) if (be[b]) l[8*b +: 8] = wd[8*b +: 8];
        shadow[{a[31:5], 5'b0}] = l;
    endfunction

    // Physical memory: answers any held strobe on the third sampled cycle.
    initial begin
        int wcnt;
        wcnt = 0;
        pmem_resp = 0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 0;
            wcnt = (pmem_read || pmem_write) ? wcnt + 1 : 0;
            if (wcnt == 3) begin
                wcnt = 0;
                pmem_resp = 1;
                if (pmem_write) begin
                    store[pmem_address] = pmem_wdata;
                    pmem_log.push_back('{1'b1, pmem_address, pmem_wdata});
                end else begin
                    pmem_rdata = store.exists(pmem_address) ? store[pmem_address] : pat(pmem_address);
                    pmem_log.push_back('{1'b0, pmem_address, pmem_rdata});
                end
            end
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] be,
                             input logic [255:0] wd, output int lat, output logic [255:0] got);
        exp_t e;
        lat = 0;
        @(negedge clk);
        mem_address = addr;
        mem_read = rd;
        mem_write = wr;
        mem_byte_enable256 = be;
        mem_wdata256 = wd;
        if (wr) shadow_write(addr, be, wd);
        exp_q.push_back('{!wr, model_line(addr)});
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_resp && lat < 200);
        got = mem_rdata256;
        e = exp_q.pop_front();
        vectors++;
        if (!mem_resp) begin
            miscompares++;
            $display("FAIL resp_timeout addr=%h: no mem_resp within %0d cycles", addr, lat);
        end else if (e.chk && got !== e.line) begin
            miscompares++;
            $display("FAIL read_data addr=%h: got %h expected %h", addr, got, e.line);
        end
        mem_read = 0;
        mem_write = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        shadow.delete();
    endtask

    task automatic test_reset;
        rst = 0;
        mem_read = 0;
        mem_write = 0;
        mem_address = '0;
        mem_byte_enable256 = '0;
        mem_wdata256 = '0;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (mem_resp !== 1'b0) begin miscompares++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); end
        if (pmem_read !== 1'b0) begin miscompares++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
        if (pmem_write !== 1'b0) begin miscompares++; $display("FAIL reset_pmem_write: got %b expected 0", pmem_write); end
        if (pmem_address !== 32'h0) begin miscompares++; $display("FAIL reset_pmem_address: got %h expected 0", pmem_address); end
        if (dut.state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        rst = 1;
    endtask

    task automatic test_cold_read;
        int lat;
        logic [255:0] got;
        pmem_log.delete();
        do_access(1, 0, 32'h40, '0, '0, lat, got);
        vectors++;
        if (pmem_log.size() != 1 || pmem_log[0].wr !== 1'b0 || pmem_log[0].addr !== 32'h40) begin
            miscompares++;
            $display("FAIL cold_fill: got %0d txns first addr %h expected one read at 00000040", pmem_log.size(), pmem_log[0].addr);
        end
        pmem_log.delete();
        do_access(1, 0, 32'h40, '0, '0, lat, got);
        vectors += 2;
        if (lat != 2) begin miscompares++; $display("FAIL hit_latency: got %0d expected 2", lat); end
        if (pmem_log.size() != 0) begin miscompares++; $display("FAIL hit_pmem_idle: got %0d txns expected 0", pmem_log.size()); end
    endtask

    task automatic test_write_hit;
        int lat;
        logic [255:0] got, a_line;
        a_line = pat(32'h40);
        pmem_log.delete();
        do_access(0, 1, 32'h40, 32'h0000_000F, {224'h0, 32'hDEADBEEF}, lat, got);
        do_access(1, 0, 32'h40, '0, '0, lat, got);
        vectors += 3;
        if (pmem_log.size() != 0) begin miscompares++; $display("FAIL write_hit_pmem: got %0d txns expected 0", pmem_log.size()); end
        if (got[31:0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_merge_low: got %h expected deadbeef", got[31:0]); end
        if (got[255:32] !== a_line[255:32]) begin miscompares++; $display("FAIL write_merge_high: got %h expected %h", got[255:32], a_line[255:32]); end
    endtask

    task automatic test_plru;
        int lat;
        logic [255:0] got, vline;
        for (int t = 0; t < 4; t++) do_access(0, 1, 32'(t << 8) | 32'h40, 32'h0000_00F0, {8{$urandom}}, lat, got);
        do_access(1, 0, 32'h40, '0, '0, lat, got);
        vline = model_line(32'h240);
        pmem_log.delete();
        do_access(1, 0, 32'h440, '0, '0, lat, got);
        vectors += 3;
        if (pmem_log.size() != 2) begin miscompares++; $display("FAIL plru_txn_count: got %0d expected 2", pmem_log.size()); end
        if (pmem_log[0].wr !== 1'b1 || pmem_log[0].addr !== 32'h240 || pmem_log[0].data !== vline) begin
            miscompares++;
            $display("FAIL plru_victim: got wr=%b addr=%h expected writeback of 00000240", pmem_log[0].wr, pmem_log[0].addr);
        end
        if (pmem_log[1].wr !== 1'b0 || pmem_log[1].addr !== 32'h440) begin
            miscompares++;
            $display("FAIL plru_fill: got wr=%b addr=%h expected read at 00000440", pmem_log[1].wr, pmem_log[1].addr);
        end
    endtask

    task automatic test_dirty_evict;
        int lat;
        logic [255:0] got, vline;
        do_reset();
        do_access(0, 1, 32'h1040, 32'h0000_FF00, {8{$urandom}}, lat, got);
        for (int t = 0; t < 3; t++) do_access(1, 0, 32'h3040 + 32'(t) * 32'h2000, '0, '0, lat, got);
        vline = model_line(32'h1040);
        pmem_log.delete();
        do_access(1, 0, 32'h2040, '0, '0, lat, got);
        vectors += 2;
        if (pmem_log[0].wr !== 1'b1 || pmem_log[0].addr !== 32'h1040 || pmem_log[0].data !== vline) begin
            miscompares++;
            $display("FAIL evict_writeback: got wr=%b addr=%h data=%h expected 00001040 data=%h", pmem_log[0].wr, pmem_log[0].addr, pmem_log[0].data, vline);
        end
        if (pmem_log.size() != 2 || pmem_log[1].wr !== 1'b0 || pmem_log[1].addr !== 32'h2040) begin
            miscompares++;
            $display("FAIL evict_fill: got %0d txns addr=%h expected read at 00002040", pmem_log.size(), pmem_log[1].addr);
        end
    endtask

    task automatic test_reset_fill;
        int lat, n;
        logic [255:0] got;
        @(negedge clk);
        mem_address = 32'h800;
        mem_read = 1;
        mem_write = 0;
        n = 0;
        while (!pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h800) begin
            miscompares++;
            $display("FAIL fill_start: got read=%b addr=%h expected 1 at 00000800", pmem_read, pmem_address);
        end
        rst = 0;
        @(negedge clk);
        vectors += 3;
        if (pmem_read !== 1'b0) begin miscompares++; $display("FAIL abort_pmem_read: got %b expected 0", pmem_read); end
        if (mem_resp !== 1'b0) begin miscompares++; $display("FAIL abort_mem_resp: got %b expected 0", mem_resp); end
        if (dut.state !== IDLE) begin miscompares++; $display("FAIL abort_state: got %0d expected IDLE", dut.state); end
        mem_read = 0;
        rst = 1;
        shadow.delete();
        pmem_log.delete();
        do_access(1, 0, 32'h800, '0, '0, lat, got);
        vectors++;
        if (pmem_log.size() != 1 || pmem_log[0].wr !== 1'b0 || pmem_log[0].addr !== 32'h800) begin
            miscompares++;
            $display("FAIL refill_after_reset: got %0d txns addr=%h expected one read at 00000800", pmem_log.size(), pmem_log[0].addr);
        end
    endtask

    task automatic test_rw_both;
        int lat;
        logic [255:0] got, wd, vline;
        wd = {8{$urandom}};
        do_access(1, 1, 32'h80, 32'h0000_00F0, wd, lat, got);
        do_access(1, 0, 32'h80, '0, '0, lat, got);
        vectors++;
        if (got[63:32] !== wd[63:32]) begin miscompares++; $display("FAIL rw_merge: got %h expected %h", got[63:32], wd[63:32]); end
        for (int t = 1; t < 4; t++) do_access(1, 0, 32'(t << 8) | 32'h80, '0, '0, lat, got);
        vline = model_line(32'h80);
        pmem_log.delete();
        do_access(1, 0, 32'h480, '0, '0, lat, got);
        vectors++;
        if (pmem_log[0].wr !== 1'b1 || pmem_log[0].addr !== 32'h80 || pmem_log[0].data !== vline) begin
            miscompares++;
            $display("FAIL rw_dirty: got wr=%b addr=%h expected writeback of 00000080", pmem_log[0].wr, pmem_log[0].addr);
        end
    endtask

    task automatic test_back_to_back;
        int lat, k;
        logic [255:0] got;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 1) << 5) | $urandom_range(0, 31);
            k = $urandom_range(0, 2);
            do_access(k != 1, k != 0, a, $urandom, {8{$urandom}}, lat, got);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_plru();
        test_dirty_evict();
        test_reset_fill();
        test_rw_both();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
